gpio_spi_seq: RTL

GPIO_SPI_SEQ -- requirements
Module: gpio_spi_seq

---
 rtl/gpio_spi_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gpio_spi_seq.sv
// SPI master bit-banged through a bitwise gpio slave: one pin write per step,
// MSB-first 8-bit transfer, MISO sampled while SCLK is high.
module gpio_spi_seq #(
    parameter int unsigned GPIO_ADDR   = 3,
    parameter int unsigned SCLK_PIN    = 0,
    parameter int unsigned MOSI_PIN    = 1,
    parameter int unsigned MISO_PIN    = 2,
    parameter int unsigned HALF_PERIOD = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [7:0]           tx_data,
    output logic [7:0]           rx_data,
    output logic                 busy,
    output logic                 done,
    output logic [GPIO_ADDR-1:0] gpio_address,
    output logic                 gpio_write_n,
    output logic [1:0]           gpio_writedata,
    input  logic [1:0]           gpio_readdata
);

    typedef enum logic [3:0] {
        StIdle, StCfgMiso, StCfgSclk, StMosi, StWait1, StRise,
        StWait2, StSample, StFall, StDone, StAbort
    } state_e;

    localparam logic [15:0]          WaitLoad = 16'(HALF_PERIOD - 1);
    localparam logic [GPIO_ADDR-1:0] SclkAddr = GPIO_ADDR'(SCLK_PIN);
    localparam logic [GPIO_ADDR-1:0] MosiAddr = GPIO_ADDR'(MOSI_PIN);
    localparam logic [GPIO_ADDR-1:0] MisoAddr = GPIO_ADDR'(MISO_PIN);

    state_e               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [7:0]           tx_q, tx_d;
    logic [7:0]           rx_sh_q, rx_sh_d;
    logic [GPIO_ADDR-1:0] addr_d;
    logic                 write_n_d;
    logic [1:0]           wdata_d;

    // Next-state logic; abort overrides every transition of an active transfer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_sh_d = rx_sh_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    tx_d    = tx_data;
                    idx_d   = 3'd7;
                    state_d = StCfgMiso;
                end
            end
            StCfgMiso: state_d = StCfgSclk;
            StCfgSclk: state_d = StMosi;
            StMosi: begin
                cnt_d   = WaitLoad;
                state_d = StWait1;
            end
            StWait1: begin
                if (cnt_q == 16'd0) state_d = StRise;
                else                cnt_d   = cnt_q - 16'd1;
            end
            StRise: begin
                cnt_d   = WaitLoad;
                state_d = StWait2;
            end
            StWait2: begin
                if (cnt_q == 16'd0) state_d = StSample;
                else                cnt_d   = cnt_q - 16'd1;
            end
            StSample: begin
                rx_sh_d = {rx_sh_q[6:0], gpio_readdata[0]};
                state_d = StFall;
            end
            StFall: begin
                if (idx_q != 3'd0) begin
                    idx_d   = idx_q - 3'd1;
                    state_d = StMosi;
                end else begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort && !(state_q inside {StIdle, StDone, StAbort})) state_d = StAbort;
    end

    // Decode gpio access for the state being entered so outputs are registered.
    always_comb begin
        addr_d    = '0;
        write_n_d = 1'b1;
        wdata_d   = 2'b00;
        case (state_d)
            StCfgMiso: begin
                addr_d    = MisoAddr;
                write_n_d = 1'b0;
                wdata_d   = 2'b00;
            end
            StCfgSclk, StFall, StAbort: begin
                addr_d    = SclkAddr;
                write_n_d = 1'b0;
                wdata_d   = 2'b10;
            end
            StMosi: begin
                addr_d    = MosiAddr;
                write_n_d = 1'b0;
                wdata_d   = {1'b1, tx_d[idx_d]};
            end
            StRise: begin
                addr_d    = SclkAddr;
                write_n_d = 1'b0;
                wdata_d   = 2'b11;
            end
            StSample: addr_d = MisoAddr;
            default: ;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            idx_q          <= 3'd0;
            cnt_q          <= 16'd0;
            tx_q           <= 8'd0;
            rx_sh_q        <= 8'd0;
            rx_data        <= 8'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            gpio_address   <= '0;
            gpio_write_n   <= 1'b1;
            gpio_writedata <= 2'b00;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            tx_q           <= tx_d;
            rx_sh_q        <= rx_sh_d;
            busy           <= !(state_d inside {StIdle, StDone});
            done           <= (state_d == StDone);
            gpio_address   <= addr_d;
            gpio_write_n   <= write_n_d;
            gpio_writedata <= wdata_d;
            if (state_d == StDone) rx_data <= rx_sh_q;
        end
    end

endmodule
